// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared op and state encodings for the serial add/sub accumulator
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } state_e;

endpackage

// File: rtl/serial_fa_cell.sv
// rtl/serial_fa_cell.sv - 1-bit full adder used by the bit-serial datapath
module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/addsub_serial_acc.sv
// rtl/addsub_serial_acc.sv - bit-serial W-bit add/sub/load/clear accumulator with N/Z/C/V flags
// Optional ADDSUB_SAT_EN: saturate the result on signed overflow.
module addsub_serial_acc
  import addsub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic         acc_sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic         v,
  output logic         z,
  output logic         n
);

  localparam int CW = $clog2(W + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   sa_q, sa_d;
  logic [W-1:0]   sb_q, sb_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic           msb_cin_q, msb_cin_d;
  logic           arith_q, arith_d;
  logic [W-1:0]   result_q, result_d;
  logic           c_out_q, c_out_d;
  logic           v_q, v_d;
  logic           z_q, z_d;
  logic           n_q, n_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           fa_sum, fa_cout;
  logic           ovf;
  logic [W-1:0]   fin_val;

  serial_fa_cell u_fa (
    .a_i (sa_q[0]),
    .b_i (sb_q[0]),
    .c_i (carry_q),
    .s_o (fa_sum),
    .c_o (fa_cout)
  );

  // After the last RUN cycle carry_q holds the carry out of the MSB.
  assign ovf = msb_cin_q ^ carry_q;

`ifdef ADDSUB_SAT_EN
  // On overflow the wrapped sign is inverted: a negative wrap means positive operands.
  always_comb begin
    fin_val = sum_q;
    if (arith_q && ovf) begin
      fin_val = sum_q[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
    end
  end
`else
  assign fin_val = sum_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    msb_cin_d = msb_cin_q;
    arith_d   = arith_q;
    result_d  = result_q;
    c_out_d   = c_out_q;
    v_d       = v_q;
    z_d       = z_q;
    n_d       = n_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op_e'(op))
            OP_ADD, OP_SUB: begin
              sa_d    = acc_sel ? result_q : a;
              sb_d    = (op_e'(op) == OP_SUB) ? ~b : b;
              carry_d = (op_e'(op) == OP_SUB);
              cnt_d   = '0;
              arith_d = 1'b1;
              state_d = S_RUN;
            end
            OP_LOAD: begin
              sum_d   = b;
              arith_d = 1'b0;
              state_d = S_FIN;
            end
            OP_CLR: begin
              sum_d   = '0;
              arith_d = 1'b0;
              state_d = S_FIN;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        sum_d   = {fa_sum, sum_q[W-1:1]};
        carry_d = fa_cout;
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          msb_cin_d = carry_q;
          state_d   = S_FIN;
        end
      end
      S_FIN: begin
        result_d = fin_val;
        c_out_d  = arith_q & carry_q;
        v_d      = arith_q & ovf;
        z_d      = (fin_val == '0);
        n_d      = fin_val[W-1];
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sa_q      <= '0;
      sb_q      <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      arith_q   <= 1'b0;
      result_q  <= '0;
      c_out_q   <= 1'b0;
      v_q       <= 1'b0;
      z_q       <= 1'b1;
      n_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      msb_cin_q <= msb_cin_d;
      arith_q   <= arith_d;
      result_q  <= result_d;
      c_out_q   <= c_out_d;
      v_q       <= v_d;
      z_q       <= z_d;
      n_q       <= n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_out_q;
  assign v      = v_q;
  assign z      = z_q;
  assign n      = n_q;

endmodule

// File: tb/tb_addsub_serial_acc.sv
// tb/tb_addsub_serial_acc.sv - scoreboard bench for addsub_serial_acc (honours ADDSUB_SAT_EN)
module tb_addsub_serial_acc;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic         acc_sel = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, c_out, v, z, n;
  logic [W-1:0] result;

  addsub_serial_acc #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .acc_sel (acc_sel),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .c_out   (c_out),
    .v       (v),
    .z       (z),
    .n       (n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         c, ov, zr, ng;
    int           dcyc;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] acc_m = '0;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural operands.
  task automatic predict(input int o, input logic sel, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input int t);
    exp_t   e;
    longint mask, smax, smin, ua, ub, sa, sb, full, exact, res;
    mask  = (longint'(1) << W) - 1;
    smax  = (longint'(1) << (W - 1)) - 1;
    smin  = -(longint'(1) << (W - 1));
    ua    = sel ? longint'(acc_m) : longint'(av);
    ub    = longint'(bv);
    sa    = (ua > smax) ? ua - (mask + 1) : ua;
    sb    = (ub > smax) ? ub - (mask + 1) : ub;
    e.c   = 1'b0;
    e.ov  = 1'b0;
    res   = 0;
    if (o == 0 || o == 1) begin
      full  = (o == 0) ? ua + ub : ua + ((~ub) & mask) + 1;
      exact = (o == 0) ? sa + sb : sa - sb;
      res   = full & mask;
      e.c   = ((full >> W) & 1) != 0;
      e.ov  = (exact > smax) || (exact < smin);
`ifdef ADDSUB_SAT_EN
      if (e.ov) res = (exact > 0) ? smax : (smin & mask);
`endif
    end else if (o == 2) begin
      res = ub;
    end
    e.res  = res[W-1:0];
    e.zr   = (res == 0);
    e.ng   = e.res[W-1];
    e.dcyc = t + ((o < 2) ? W + 1 : 1);
    acc_m  = e.res;
    sbq.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the start cycle.
  task automatic issue(input int o, input logic sel, input logic [W-1:0] av, input logic [W-1:0] bv);
    int guard = 0;
    while (busy !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      chk("idle_timeout", 64'd0, 64'd1);
      return;
    end
    op      = 2'(o);
    acc_sel = sel;
    a       = av;
    b       = bv;
    start   = 1'b1;
    predict(o, sel, av, bv, cyc);
    @(negedge clk);
    start   = 1'b0;
    op      = 2'($urandom_range(0, 3));
    acc_sel = 1'($urandom_range(0, 1));
    a       = W'($urandom);
    b       = W'($urandom);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && done === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.dcyc));
          @(negedge clk);
          chk("done_width", 64'(done), 64'd0);
          chk("busy_after", 64'(busy), 64'd0);
          chk("result", 64'(result), 64'(e.res));
          chk("c_out", 64'(c_out), 64'(e.c));
          chk("v", 64'(v), 64'(e.ov));
          chk("z", 64'(z), 64'(e.zr));
          chk("n", 64'(n), 64'(e.ng));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] edge_vals [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

  initial begin : driver
    int o;
    int guard;
    repeat (3) @(negedge clk);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_z", 64'(z), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_flags", {61'd0, c_out, v, n}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 1'b0, 8'h05, 8'h03);
    issue(0, 1'b0, 8'h7F, 8'h01);
    issue(1, 1'b0, 8'h03, 8'h05);
    issue(1, 1'b0, 8'h80, 8'h01);
    issue(2, 1'b0, 8'h00, 8'h0A);
    issue(1, 1'b1, 8'h55, 8'h0A);
    issue(3, 1'b0, 8'h33, 8'h44);

    // Starts during RUN must be dropped.
    issue(0, 1'b0, 8'h21, 8'h42);
    @(negedge clk);
    chk("busy_in_run", 64'(busy), 64'd1);
    start = 1'b1;
    op    = 2'b10;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    op    = 2'b11;
    @(negedge clk);
    start = 1'b0;

    // Reset mid-RUN abandons the operation.
    issue(2, 1'b0, 8'h00, 8'h11);
    issue(0, 1'b1, 8'h00, 8'h22);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    chk("mid_rst_z", 64'(z), 64'd1);
    chk("mid_rst_flags", {61'd0, c_out, v, n}, 64'd0);
    void'(sbq.pop_back());
    acc_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    issue(0, 1'b1, 8'h00, 8'h09);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] av, bv;
      o  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 3));
      av = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
      bv = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
      issue(o, 1'($urandom_range(0, 1)), av, bv);
    end

    guard = 0;
    while (sbq.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", 64'(sbq.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
